// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter: state encodings,
// active-low grant polarity constants, and a modular increment helper.
package mem_bus_arbiter_pkg;

    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    // (v + 1) mod n without a divider; v is assumed to be below n
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin picker: the first asserted request at or after ptr, searching
// upward with wrap-around.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    int unsigned j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[IDXW'(j)]) begin
                valid = 1'b1;
                idx   = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between NMASTER cores using an active-low
// request/grant handshake, round-robin order and a hold watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NMASTER = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned IDXW   = $clog2(NMASTER)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NMASTER-1:0]         m_breq_n,
    input  logic [NMASTER-1:0]         m_done,
    input  logic [NMASTER-1:0]         m_memread,
    input  logic [NMASTER-1:0]         m_memwrite,
    input  logic [NMASTER*WIDTH-1:0]   m_adr,
    input  logic [NMASTER*WIDTH-1:0]   m_wdata,
    output logic [NMASTER-1:0]         bgrt_n,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [WIDTH-1:0]           mem_adr,
    output logic [WIDTH-1:0]           mem_wdata,
    output logic [IDXW-1:0]            owner,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [NMASTER-1:0]  bgrt_d;
    logic [IDXW-1:0]     owner_d;
    logic [IDXW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_d;
    logic                terr_d;
    logic                pick_valid;
    logic [IDXW-1:0]     pick_idx;

    rr_pick #(
        .N    (NMASTER),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req   (~m_breq_n),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            bgrt_n      <= {NMASTER{DISABLE_N}};
            owner       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            bgrt_n      <= bgrt_d;
            owner       <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            timeout_err <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bgrt_d  = bgrt_n;
        owner_d = owner;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        terr_d  = timeout_err;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    bgrt_d  = ~(NMASTER'(1) << pick_idx);
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                cnt_d = cnt_q + CW'(1);
                // done takes precedence over the watchdog in the same cycle
                if (m_done[owner] || cnt_q == CW'(TIMEOUT - 1)) begin
                    bgrt_d  = {NMASTER{DISABLE_N}};
                    ptr_d   = IDXW'(wrap_inc(32'(owner), NMASTER));
                    busy_d  = 1'b0;
                    state_d = ARB_GAP;
                    if (!m_done[owner]) begin
                        terr_d = 1'b1;
                    end
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                bgrt_d  = {NMASTER{DISABLE_N}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // Owner's bus goes straight to memory while granted; quiet otherwise
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (state_q == ARB_GRANT) begin
            mem_read  = m_memread[owner];
            mem_write = m_memwrite[owner];
            mem_adr   = m_adr[32'(owner)*WIDTH +: WIDTH];
            mem_wdata = m_wdata[32'(owner)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: four cores, TIMEOUT=8, hand-computed
// grant sequences, bus-mux and watchdog expectations.
module tb_mem_bus_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NM-1:0]   m_breq_n;
    logic [NM-1:0]   m_done;
    logic [NM-1:0]   m_memread;
    logic [NM-1:0]   m_memwrite;
    logic [NM*W-1:0] m_adr;
    logic [NM*W-1:0] m_wdata;
    logic [NM-1:0]   bgrt_n;
    logic            mem_read;
    logic            mem_write;
    logic [W-1:0]    mem_adr;
    logic [W-1:0]    mem_wdata;
    logic [1:0]      owner;
    logic            busy;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .NMASTER (NM),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_breq_n    (m_breq_n),
        .m_done      (m_done),
        .m_memread   (m_memread),
        .m_memwrite  (m_memwrite),
        .m_adr       (m_adr),
        .m_wdata     (m_wdata),
        .bgrt_n      (bgrt_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [W-1:0] adr, input logic [W-1:0] wd);
        m_adr[i*W +: W]   = adr;
        m_wdata[i*W +: W] = wd;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        m_breq_n   = '1;
        m_done     = '0;
        m_memread  = '0;
        m_memwrite = '0;
        m_adr      = '0;
        m_wdata    = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pulse done for the current owner; the release edge follows
    task automatic release_core(input int i);
        m_done = NM'(1) << i;
        tick();
        m_done = '0;
    endtask

    initial begin
        int exp_order[5];
        logic [NM-1:0] exp_g;
        exp_order = '{0, 1, 2, 3, 0};

        // 1: single request, grant latency, address pass-through, release
        do_reset();
        check("rst_bgrt", 64'(bgrt_n), 64'(4'b1111));
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);
        check("rst_mread", 64'(mem_read), 64'd0);
        m_breq_n = 4'b1110;
        tick();
        check("t1_grant", 64'(bgrt_n), 64'(4'b1110));
        check("t1_busy", 64'(busy), 64'd1);
        m_breq_n = 4'b1111;
        set_core(0, 32'h0000_1000, 32'hDEAD_BEEF);
        set_core(1, 32'h0000_2000, 32'h1111_1111);
        m_memread = 4'b0001;
        #1;
        check("t1_adr", 64'(mem_adr), 64'h1000);
        check("t1_mread", 64'(mem_read), 64'd1);
        set_core(0, 32'h0000_1004, 32'hDEAD_BEEF);
        #1;
        check("t1_adr_track", 64'(mem_adr), 64'h1004);
        release_core(0);
        check("t1_release", 64'(bgrt_n), 64'(4'b1111));
        check("t1_gap_mread", 64'(mem_read), 64'd0);
        check("t1_gap_adr", 64'(mem_adr), 64'd0);

        // 2: everyone requests; rr order 0,1,2,3,0 with a GAP each time
        do_reset();
        m_breq_n = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = ~(NM'(1) << exp_order[k]);
            check($sformatf("t2_grant%0d", k), 64'(bgrt_n), 64'(exp_g));
            check($sformatf("t2_owner%0d", k), 64'(owner), 64'(exp_order[k]));
            tick();
            tick();
            release_core(exp_order[k]);
            check($sformatf("t2_gap%0d", k), 64'(bgrt_n), 64'(4'b1111));
            check($sformatf("t2_gapbusy%0d", k), 64'(busy), 64'd0);
            tick();
            check($sformatf("t2_idle%0d", k), 64'(bgrt_n), 64'(4'b1111));
            tick();
        end

        // 3: owner 2 hangs; watchdog releases after 8 GRANT cycles
        do_reset();
        m_breq_n = 4'b0011;
        tick();
        check("t3_grant2", 64'(bgrt_n), 64'(4'b1011));
        m_breq_n = 4'b0111;
        for (int k = 0; k < 7; k++) tick();
        check("t3_hold7", 64'(bgrt_n), 64'(4'b1011));
        check("t3_terr_pre", 64'(timeout_err), 64'd0);
        tick();
        check("t3_forced", 64'(bgrt_n), 64'(4'b1111));
        check("t3_terr", 64'(timeout_err), 64'd1);
        tick();
        tick();
        check("t3_next3", 64'(bgrt_n), 64'(4'b0111));
        check("t3_owner3", 64'(owner), 64'd3);
        m_breq_n = 4'b1111;
        release_core(3);
        tick();
        check("t3_terr_sticky", 64'(timeout_err), 64'd1);

        // 4: done coincides with watchdog expiry; stray done from core 3
        do_reset();
        m_breq_n = 4'b1101;
        tick();
        check("t4_grant1", 64'(bgrt_n), 64'(4'b1101));
        m_breq_n = 4'b1111;
        m_done   = 4'b1000;
        for (int k = 0; k < 7; k++) tick();
        m_done = '0;
        check("t4_ignore_d3", 64'(bgrt_n), 64'(4'b1101));
        release_core(1);
        check("t4_release", 64'(bgrt_n), 64'(4'b1111));
        check("t4_terr", 64'(timeout_err), 64'd0);

        // 5: non-owner write strobes stay off the memory bus
        do_reset();
        m_memwrite = 4'b1000;
        set_core(0, 32'hA000_0000, 32'h0000_00AA);
        set_core(3, 32'hB000_0000, 32'h0000_00BB);
        #1;
        check("t5_idle_mw", 64'(mem_write), 64'd0);
        m_breq_n = 4'b1110;
        tick();
        m_breq_n = 4'b1111;
        check("t5_nonowner_mw", 64'(mem_write), 64'd0);
        m_memwrite = 4'b1001;
        #1;
        check("t5_owner_mw", 64'(mem_write), 64'd1);
        check("t5_adr", 64'(mem_adr), 64'hA000_0000);
        check("t5_wdata", 64'(mem_wdata), 64'hAA);
        release_core(0);
        m_memwrite = 4'b1111;
        #1;
        check("t5_gap_mw", 64'(mem_write), 64'd0);
        check("t5_gap_wd", 64'(mem_wdata), 64'd0);
        m_memwrite = '0;

        // 6: reset in the middle of a tenure; pointer returns to 0
        do_reset();
        m_breq_n = 4'b1101;
        tick();
        m_breq_n = 4'b1111;
        release_core(1);
        tick();
        m_breq_n = 4'b1101;
        tick();
        check("t6_grant1", 64'(bgrt_n), 64'(4'b1101));
        m_breq_n = 4'b1111;
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_bgrt", 64'(bgrt_n), 64'(4'b1111));
        check("t6_rst_owner", 64'(owner), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        reset    = 1'b0;
        m_breq_n = 4'b0000;
        tick();
        check("t6_next0", 64'(bgrt_n), 64'(4'b1110));
        check("t6_owner0", 64'(owner), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
